// File: rtl/block_field_pkg.sv
// Shared constants and types for the falling-block field:
// geometry, FSM encoding, LFSR taps/seed and the score ceiling.
package block_field_pkg;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 8;
    localparam int unsigned ROW_IDX_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StClear,
        StWrite
    } state_t;

    // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [3:0] SCORE_MAX    = 4'd10;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 4'd1;
    endfunction

endpackage

// File: rtl/row_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the spawn column of each new top row.
module row_lfsr import block_field_pkg::*; #(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] lfsr_q;
    logic       feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (step) begin
            lfsr_q <= {lfsr_q[6:0], feedback};
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/block_row_writer.sv
// Owns the falling-block field and streams its rows to the display block array.
// Define BLOCK_ROW_WRITER_SCORE_EN to build the hits/misses counters.
module block_row_writer #(
    parameter int unsigned ROWS = block_field_pkg::ROWS,
    parameter int unsigned COLS = block_field_pkg::COLS,
    parameter logic [7:0]  SEED = block_field_pkg::DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    update_tick,
    input  logic                    btn,
    input  logic                    wr_ready,
    output logic                    write_strobe,
    output logic [$clog2(ROWS)-1:0] row_index,
    output logic [COLS-1:0]         val,
    output logic                    busy,
    output logic [3:0]              hits,
    output logic [3:0]              misses
);
    import block_field_pkg::*;

    localparam int unsigned IdxW = $clog2(ROWS);
    localparam logic [IdxW-1:0] LastRow = IdxW'(ROWS - 1);

    state_t                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  field_q, field_d;
    logic                       strobe_q, strobe_d;
    logic [IdxW-1:0]            idx_q, idx_d, idx_next;
    logic [COLS-1:0]            val_q, val_d;
    logic                       single_q, single_d;
    logic                       tick_pend_q, tick_pend_d;
    logic                       btn_pend_q, btn_pend_d;
    logic                       lfsr_step;
    logic [7:0]                 lfsr;
    logic [COLS-1:0]            spawn;

    row_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .state (lfsr)
    );

    assign spawn = COLS'(1) << lfsr[$clog2(COLS)-1:0];

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        strobe_d    = strobe_q;
        idx_d       = idx_q;
        val_d       = val_q;
        single_d    = single_q;
        tick_pend_d = tick_pend_q;
        btn_pend_d  = btn_pend_q;
        lfsr_step   = 1'b0;
        idx_next    = idx_q + IdxW'(1);

        unique case (state_q)
            StIdle: begin
                if (update_tick || tick_pend_q) begin
                    state_d     = StShift;
                    tick_pend_d = 1'b0;
                    if (btn) btn_pend_d = 1'b1;
                end else if (btn || btn_pend_q) begin
                    state_d    = StClear;
                    btn_pend_d = 1'b0;
                end
            end
            StShift: begin
                for (int r = ROWS - 1; r > 0; r--) begin
                    field_d[r] = field_q[r-1];
                end
                field_d[0] = spawn;
                lfsr_step  = 1'b1;
                strobe_d   = 1'b1;
                idx_d      = '0;
                val_d      = spawn;
                single_d   = 1'b0;
                state_d    = StWrite;
            end
            StClear: begin
                field_d[ROWS-1] = '0;
                btn_pend_d      = 1'b0;
                strobe_d        = 1'b1;
                idx_d           = LastRow;
                val_d           = '0;
                single_d        = 1'b1;
                state_d         = StWrite;
            end
            StWrite: begin
                if (wr_ready) begin
                    if (single_q || idx_q == LastRow) begin
                        strobe_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        idx_d = idx_next;
                        val_d = field_q[idx_next];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Requests arriving while busy are remembered once; set beats clear.
        if (state_q != StIdle) begin
            if (update_tick) tick_pend_d = 1'b1;
            if (btn)         btn_pend_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            field_q     <= '0;
            strobe_q    <= 1'b0;
            idx_q       <= '0;
            val_q       <= '0;
            single_q    <= 1'b0;
            tick_pend_q <= 1'b0;
            btn_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            strobe_q    <= strobe_d;
            idx_q       <= idx_d;
            val_q       <= val_d;
            single_q    <= single_d;
            tick_pend_q <= tick_pend_d;
            btn_pend_q  <= btn_pend_d;
        end
    end

`ifdef BLOCK_ROW_WRITER_SCORE_EN
    logic [3:0] hits_q, misses_q;
    logic       hit_evt, miss_evt;

    assign hit_evt  = (state_q == StClear) && (|field_q[ROWS-1]);
    assign miss_evt = (state_q == StShift) && (|field_q[ROWS-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (hit_evt)  hits_q   <= sat_inc(hits_q);
            if (miss_evt) misses_q <= sat_inc(misses_q);
        end
    end

    assign hits   = hits_q;
    assign misses = misses_q;
`else
    assign hits   = 4'd0;
    assign misses = 4'd0;
`endif

    assign write_strobe = strobe_q;
    assign row_index    = idx_q;
    assign val          = val_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: doc/block_row_writer.md
Name: block_row_writer

Overview:
- Producer side of the block-array row-write interface: owns the 8x8 falling-block field and pushes rows to the display's block array via a strobe/ready handshake.
- Sits between the speed-divided update tick and the VGA block-array storage.
- On each tick it does three things:
  - shifts the field down one row;
  - spawns a new top row from an LFSR;
  - streams all 8 rows to the display.
- A player button clears the bottom row and scores a hit.

Parameters:
- ROWS, 8, number of field rows; rowIndex width is clog2(ROWS).
- COLS, 8, bits per row; equals the val width.
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock (display pixel-domain clock).
- reset  in  1  asynchronous, active-low reset.
- update_tick  in  1  single-cycle pulse requesting one field step.
- btn  in  1  single-cycle debounced button pulse.
- wr_ready  in  1  display side can accept a row write this cycle.
- write_strobe  out  1  row write valid.
- row_index  out  3  row being written (0 = top).
- val  out  8  row contents; bit i = block present in column i.
- busy  out  1  high while not IDLE.
- hits  out  4  button hits counter (optional feature).
- misses  out  4  nonzero rows dropped off the bottom (optional feature).

Behaviour:
- Reset (reset low, async) forces:
  - field = all zero, LFSR = SEED, state = IDLE;
  - write_strobe = 0, row_index = 0, val = 0, busy = 0;
  - tick_pend = 0, btn_pend = 0, hits = 0, misses = 0.
- States:
  - IDLE: on update_tick or tick_pend, go to SHIFT and clear tick_pend. Else, on btn or btn_pend, go to CLEAR.
  - SHIFT, one cycle:
    - field[r] <= field[r-1] for r = 7..1.
    - field[0] <= 8'b1 << lfsr[2:0].
    - LFSR steps once: 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit 0.
    - If old field[7] != 0, misses increments.
    - Go to WRITE with row counter = 0.
  - CLEAR, one cycle:
    - If field[7] != 0: field[7] <= 0 and hits increments. Otherwise nothing changes.
    - Clear btn_pend, go to WRITE with row counter = 7, single-row mode.
  - WRITE:
    - write_strobe = 1, row_index = counter, val = field[counter]. These are registered and change only after acceptance.
    - A transfer occurs when write_strobe & wr_ready. Strobe, index and val hold stable until accepted.
    - Full mode: counter 0..7, one accepted transfer per row. After row 7 is accepted, strobe drops the next cycle and the FSM returns to IDLE.
    - Single-row mode: one transfer of row 7, then IDLE.
    - Back-to-back transfers with wr_ready held high take exactly 1 cycle per row: a full refresh is 8 strobe cycles, SHIFT to IDLE in 10 cycles.
- Latency:
  - update_tick to first strobe: 2 cycles (IDLE→SHIFT→WRITE).
  - Full field with wr_ready=1: strobe high 8 consecutive cycles.
- Simultaneous events:
  - update_tick and btn in the same IDLE cycle: the tick wins, btn sets btn_pend.
  - update_tick outside IDLE: sets tick_pend, which is 1-deep; further ticks are dropped.
  - btn outside IDLE: sets btn_pend, 1-deep.
  - btn_pend is serviced only in IDLE and only with no tick pending.
- Counters: hits and misses are 4-bit and saturate at 4'd10; no wrap.
- Reset mid-WRITE: strobe drops asynchronously, and no partial state survives.
- busy = (state != IDLE).

Optional Feature:
- BLOCK_ROW_WRITER_SCORE_EN.
- Defined: the hits/misses counters exist as described.
- Undefined: no counter registers; hits and misses are tied to 4'd0. The CLEAR behaviour on the field is unchanged.

Decomposition:
- Shared package block_field_pkg holds:
  - ROWS, COLS, ROW_IDX_W;
  - state encoding (IDLE, SHIFT, CLEAR, WRITE);
  - LFSR tap mask 8'hB8 and default SEED;
  - SCORE_MAX = 4'd10.
- One sub-module: row_lfsr, an 8-bit LFSR with step enable, async active-low reset to SEED, and 8-bit state output.

Test Plan:
- Release reset, one update_tick, wr_ready=1:
  - SHIFT LFSR value is SEED 8'hA5, lfsr[2:0]=5, so field[0]=8'h20.
  - Strobes 0..7 appear on 8 consecutive cycles: val 8'h20 then 8'h00 x7.
  - busy is low 10 cycles after the tick.
- wr_ready held 0 for 5 cycles on row 3: strobe, row_index=3 and val are stable for all 5 cycles; row 4 follows one cycle after ready rises.
- 8 ticks then a 9th (wr_ready=1): the top-row spawn reaches row 7; the 9th SHIFT drops it, so misses=1. Then btn with field[7]≠0: a single row-7 write with val=0, hits=1.
- update_tick and btn in the same IDLE cycle: full refresh first, then CLEAR and a single row-7 write. A third tick during WRITE is captured once; a fourth is dropped.
- Drive 12 misses: misses saturates at 10. With the macro undefined, hits and misses stay 0.
- Assert reset during WRITE row 4: write_strobe=0 and val=0 immediately; after release, field is zero and the next tick yields val 8'h20 on row 0.
